// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with independent rise/fall dead bands and latched fault shutdown.
// Optional minimum on-time enforcement is enabled by defining PWM_DEADTIME_MINPULSE_EN.
module pwm_deadtime #(
    parameter int DT_W      = 8,
    parameter int MIN_PULSE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            dead_active,
    output logic            fault_latched
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        DEAD_H = 3'd1,
        H_ON   = 3'd2,
        DEAD_L = 3'd3,
        L_ON   = 3'd4
    } state_t;

    if (DT_W < 1) begin : g_bad_dt_w
        $error("DT_W must be at least 1");
    end
    if (MIN_PULSE < 1) begin : g_bad_min_pulse
        $error("MIN_PULSE must be at least 1");
    end

    state_t          state;
    state_t          state_next;
    logic            s1;
    logic            s2;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_next;
    logic            fault_next;
    logic            h_next;
    logic            l_next;
    logic            dead_next;
    logic            on_hold;

    // pwm_in arrives from the divided PWM clock domain; only s2 is safe to use.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

`ifdef PWM_DEADTIME_MINPULSE_EN
    localparam int ON_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
    localparam logic [ON_W-1:0] ON_LOAD = ON_W'(MIN_PULSE - 1);

    logic [ON_W-1:0] on_tmr;
    logic [ON_W-1:0] on_tmr_next;
    logic            entering_on;

    assign on_hold     = (on_tmr != '0);
    assign entering_on = ((state_next == H_ON) || (state_next == L_ON)) && (state_next != state);

    always_comb begin
        on_tmr_next = on_tmr;
        if (entering_on) begin
            on_tmr_next = ON_LOAD;
        end else if (on_hold) begin
            on_tmr_next = on_tmr - ON_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            on_tmr <= '0;
        end else begin
            on_tmr <= on_tmr_next;
        end
    end
`else
    assign on_hold = 1'b0;
`endif

    // Fault sampling wins over a simultaneous clear.
    always_comb begin
        fault_next = fault_latched;
        if (fault_in) begin
            fault_next = 1'b1;
        end else if (fault_clr) begin
            fault_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (fault_in || fault_latched || !en) begin
            state_next = OFF;
        end else begin
            case (state)
                OFF: begin
                    if (s2) begin
                        state_next = DEAD_H;
                        cnt_next   = dt_rise;
                    end else begin
                        state_next = DEAD_L;
                        cnt_next   = dt_fall;
                    end
                end
                H_ON: begin
                    if (!s2 && !on_hold) begin
                        state_next = DEAD_L;
                        cnt_next   = dt_fall;
                    end
                end
                L_ON: begin
                    if (s2 && !on_hold) begin
                        state_next = DEAD_H;
                        cnt_next   = dt_rise;
                    end
                end
                // Aborting a dead band is safe: the side being approached never turned on.
                DEAD_H: begin
                    if (!s2) begin
                        state_next = L_ON;
                    end else if (cnt == '0) begin
                        state_next = H_ON;
                    end else begin
                        cnt_next = cnt - DT_W'(1);
                    end
                end
                DEAD_L: begin
                    if (s2) begin
                        state_next = H_ON;
                    end else if (cnt == '0) begin
                        state_next = L_ON;
                    end else begin
                        cnt_next = cnt - DT_W'(1);
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        h_next    = 1'b0;
        l_next    = 1'b0;
        dead_next = 1'b0;
        case (state_next)
            H_ON:           h_next    = 1'b1;
            L_ON:           l_next    = 1'b1;
            DEAD_H, DEAD_L: dead_next = 1'b1;
            default:        ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= OFF;
            cnt           <= '0;
            fault_latched <= 1'b0;
            pwm_h         <= 1'b0;
            pwm_l         <= 1'b0;
            dead_active   <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            fault_latched <= fault_next;
            pwm_h         <= h_next;
            pwm_l         <= l_next;
            dead_active   <= dead_next;
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios plus randomized traffic against a side/on behavioural model.
module tb_pwm_deadtime;

    localparam int DT_W = 8;
`ifdef PWM_DEADTIME_MINPULSE_EN
    localparam int MINP = 16;
`else
    localparam int MINP = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            pwm_in = 1'b0;
    logic [DT_W-1:0] dt_rise = '0;
    logic [DT_W-1:0] dt_fall = '0;
    logic            fault_in = 1'b0;
    logic            fault_clr = 1'b0;
    logic            pwm_h;
    logic            pwm_l;
    logic            dead_active;
    logic            fault_latched;

    int checks = 0;
    int failures = 0;

    pwm_deadtime #(.DT_W(DT_W), .MIN_PULSE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pwm_in       (pwm_in),
        .dt_rise      (dt_rise),
        .dt_fall      (dt_fall),
        .fault_in     (fault_in),
        .fault_clr    (fault_clr),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .dead_active  (dead_active),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    // Model: 'act' = driving, 'side' = level being followed (1 = high side), 'on' = past the dead band.
    int m_s1 = 0, m_s2 = 0, m_rem = 0, m_tmr = 0;
    bit m_fault = 0, m_act = 0, m_on = 0, m_side = 0;
    bit m_h = 0, m_l = 0, m_dead = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_rem = 0; m_tmr = 0;
            m_fault = 0; m_act = 0; m_on = 0; m_side = 0;
        end else begin
            if (fault_in || m_fault || !en) begin
                m_act = 0;
            end else if (!m_act) begin
                m_act = 1; m_on = 0; m_side = (m_s2 != 0);
                m_rem = m_side ? int'(dt_rise) : int'(dt_fall);
            end else if (m_on) begin
                if (m_tmr > 0) m_tmr--;
                else if ((m_s2 != 0) != m_side) begin
                    m_side = (m_s2 != 0); m_on = 0;
                    m_rem = m_side ? int'(dt_rise) : int'(dt_fall);
                end
            end else begin
                if ((m_s2 != 0) != m_side) begin
                    m_side = (m_s2 != 0); m_on = 1; m_tmr = MINP - 1;
                end else if (m_rem == 0) begin
                    m_on = 1; m_tmr = MINP - 1;
                end else begin
                    m_rem--;
                end
            end
            if (fault_in) m_fault = 1;
            else if (fault_clr) m_fault = 0;
            m_s2 = m_s1;
            m_s1 = int'(pwm_in);
        end
        m_h = m_act && m_on && m_side;
        m_l = m_act && m_on && !m_side;
        m_dead = m_act && !m_on;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("model_h", 32'(pwm_h), 32'(m_h));
        chk("model_l", 32'(pwm_l), 32'(m_l));
        chk("model_dead", 32'(dead_active), 32'(m_dead));
        chk("model_fault", 32'(fault_latched), 32'(m_fault));
        chk("no_overlap", 32'(pwm_h & pwm_l), 32'd0);
    endtask

    initial begin
        int run;
        int gaps;
        int hw;

        // Reset, then first entry into DEAD_L with dt_fall=6.
        en = 1'b1; pwm_in = 1'b0; dt_fall = 8'd6; dt_rise = 8'd4;
        cyc(); cyc();
        chk("rst_h", 32'(pwm_h), 0);
        chk("rst_l", 32'(pwm_l), 0);
        chk("rst_dead", 32'(dead_active), 0);
        chk("rst_fault", 32'(fault_latched), 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("init_dead", 32'(dead_active), 1);
            chk("init_dead_l", 32'(pwm_l), 0);
        end
        cyc();
        chk("init_l_on", 32'(pwm_l), 1);
        chk("init_h_off", 32'(pwm_h), 0);
        chk("init_dead_off", 32'(dead_active), 0);

        // Rising edge with dt_rise=4: pwm_l drops after k+2, pwm_h rises after k+7.
        pwm_in = 1'b1;
        cyc(); chk("rise_l_k", 32'(pwm_l), 1);
        cyc(); chk("rise_l_k1", 32'(pwm_l), 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rise_gap", 32'({pwm_h, pwm_l, dead_active}), 32'b001);
        end
        cyc();
        chk("rise_h_on", 32'({pwm_h, pwm_l}), 32'b10);

        // Back to L_ON, then a 3-cycle pulse shorter than the dead band must abort.
        pwm_in = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        chk("back_l_on", 32'(pwm_l), 1);
        dt_rise = 8'd10;
        pwm_in = 1'b1;
        cyc(); cyc(); cyc();
        pwm_in = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("abort_h_never", 32'(pwm_h), 0);
            if (i < 3) chk("abort_dead", 32'(dead_active), 1);
            if (i == 3) chk("abort_l_back", 32'(pwm_l), 1);
        end

        // Zero dead time, square wave period 20: every gap is exactly one cycle.
        dt_rise = 8'd0; dt_fall = 8'd0;
        run = 0; gaps = 0;
        for (int i = 0; i < 80; i++) begin
            if (i % 10 == 0) pwm_in = ~pwm_in;
            cyc();
            if (!pwm_h && !pwm_l) run++;
            else begin
                if (run > 0) begin
                    chk("sq_gap_len", 32'(run), 1);
                    gaps++;
                end
                run = 0;
            end
        end
`ifndef PWM_DEADTIME_MINPULSE_EN
        chk("sq_gap_count", 32'(gaps), 8);
`endif

        // Fault from H_ON, hold while pwm_in toggles, clear, re-entry via dead band.
        pwm_in = 1'b1; dt_rise = 8'd3;
        for (int i = 0; i < 12; i++) cyc();
        chk("pre_fault_h", 32'(pwm_h), 1);
        fault_in = 1'b1;
        cyc();
        chk("fault_outs", 32'({pwm_h, pwm_l}), 0);
        chk("fault_set", 32'(fault_latched), 1);
        fault_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) pwm_in = ~pwm_in;
            cyc();
            chk("fault_hold", 32'({fault_latched, pwm_h, pwm_l}), 32'b100);
        end
        pwm_in = 1'b1;
        cyc(); cyc(); cyc();
        fault_in = 1'b1; fault_clr = 1'b1;
        cyc();
        chk("clr_blocked", 32'(fault_latched), 1);
        fault_in = 1'b0;
        cyc();
        chk("clr_done", 32'(fault_latched), 0);
        chk("clr_still_off", 32'({pwm_h, pwm_l, dead_active}), 0);
        fault_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("reentry_dead", 32'({pwm_h, pwm_l, dead_active}), 32'b001);
        end
        cyc();
        chk("reentry_h", 32'(pwm_h), 1);

        // Reset in the middle of operation.
        rst = 1'b1;
        cyc();
        chk("midrst_outs", 32'({pwm_h, pwm_l, dead_active, fault_latched}), 0);
        rst = 1'b0;

`ifdef PWM_DEADTIME_MINPULSE_EN
        // A 5-cycle pulse still produces a MIN_PULSE-wide high-side pulse.
        pwm_in = 1'b0; dt_rise = 8'd0; dt_fall = 8'd0;
        for (int i = 0; i < 30; i++) cyc();
        pwm_in = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        pwm_in = 1'b0;
        hw = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (pwm_h) hw++;
        end
        chk("minpulse_width", 32'(hw), 16);
`else
        hw = 0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) pwm_in = ~pwm_in;
            en = ($urandom_range(63) != 0);
            fault_in = ($urandom_range(199) == 0);
            fault_clr = ($urandom_range(19) == 0);
            if ($urandom_range(15) == 0) dt_rise = 8'($urandom_range(11));
            if ($urandom_range(15) == 0) dt_fall = 8'($urandom_range(11));
            rst = ($urandom_range(499) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
